// File: rtl/spi_sram_model.sv
// Behavioural SPI SRAM: READ, FAST_READ, WRITE, RDMR and WRMR with byte, page and
// sequential addressing. Every register samples on the rising edge of sclk.
//
// state   | meaning
// IDLE    | first edge with ce high, si not sampled
// CMD     | shifting in the 8-bit command
// ADDR    | shifting in the 24-bit address
// DUMMY   | FAST_READ wait cycles, si ignored
// RD_DATA | streaming memory bytes out on so
// WR_DATA | shifting in bytes and writing memory
// RD_MR   | streaming {mode, 6'b0} out on so
// WR_MR   | shifting in a new mode byte
// IGNORE  | parked until ce drops
module spi_sram_model #(
    parameter string INIT_FILE    = "",
    parameter int    ADDR_BITS    = 24,
    parameter int    PAGE_BYTES   = 32,
    parameter int    DUMMY_CYCLES = 8
) (
    input  logic       sclk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       si,
    output logic       so,
    output logic       so_oe,
    output logic [1:0] mode
);
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FAST  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
    localparam logic [7:0] CMD_WRMR  = 8'h01;
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(PAGE_BYTES - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, RD_MR, WR_MR, IGNORE
    } state_t;

    state_t               state;
    logic [4:0]           idx;
    logic [7:0]           dummy_cnt;
    logic [23:0]          shift_sr;
    logic [7:0]           cmd;
    logic [7:0]           rd_byte;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [7:0]           mem [0:(2**ADDR_BITS)-1];

    logic [23:0]          sr_next;
    logic [ADDR_BITS-1:0] sampled_addr;
    logic [ADDR_BITS-1:0] next_addr;
    logic                 mem_we;

    assign sr_next      = {shift_sr[22:0], si};
    assign sampled_addr = sr_next[ADDR_BITS-1:0];
    assign mem_we       = reset_n && ce && (state == WR_DATA) && (idx == 5'd7);

    // Page mode only carries within the low page-offset bits.
    always_comb begin
        next_addr = cur_addr + ADDR_ONE;
        if (mode == MODE_PAGE)
            next_addr = (cur_addr & ~PAGE_MASK) | ((cur_addr + ADDR_ONE) & PAGE_MASK);
    end

    always_ff @(posedge sclk) begin
        if (mem_we) mem[cur_addr] <= sr_next[7:0];
    end

    always_ff @(posedge sclk) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= 5'd0;
            so    <= 1'b0;
            so_oe <= 1'b0;
            mode  <= 2'b01;
        end else if (!ce) begin
            state <= IDLE;
            idx   <= 5'd0;
            so_oe <= 1'b0;
        end else begin
            so_oe <= 1'b0;
            case (state)
                IDLE: begin
                    state <= CMD;
                    idx   <= 5'd0;
                end
                CMD: begin
                    shift_sr <= sr_next;
                    idx      <= idx + 5'd1;
                    if (idx == 5'd7) begin
                        idx <= 5'd0;
                        cmd <= sr_next[7:0];
                        case (sr_next[7:0])
                            CMD_READ, CMD_FAST, CMD_WRITE: state <= ADDR;
                            CMD_RDMR: begin
                                state   <= RD_MR;
                                rd_byte <= {mode, 6'b0};
                            end
                            CMD_WRMR: state <= WR_MR;
                            default:  state <= IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    shift_sr <= sr_next;
                    idx      <= idx + 5'd1;
                    if (idx == 5'd23) begin
                        idx      <= 5'd0;
                        cur_addr <= sampled_addr;
                        if (cmd == CMD_WRITE) begin
                            state <= WR_DATA;
                        end else if (cmd == CMD_FAST && DUMMY_CYCLES != 0) begin
                            state     <= DUMMY;
                            dummy_cnt <= DUMMY_LAST;
                        end else begin
                            state   <= RD_DATA;
                            rd_byte <= mem[sampled_addr];
                        end
                    end
                end
                DUMMY: begin
                    if (dummy_cnt == 8'd0) begin
                        state   <= RD_DATA;
                        rd_byte <= mem[cur_addr];
                    end else begin
                        dummy_cnt <= dummy_cnt - 8'd1;
                    end
                end
                RD_DATA: begin
                    so      <= rd_byte[7];
                    so_oe   <= 1'b1;
                    rd_byte <= {rd_byte[6:0], 1'b0};
                    idx     <= idx + 5'd1;
                    if (idx == 5'd7) begin
                        idx <= 5'd0;
                        if (mode == MODE_BYTE) begin
                            state <= IGNORE;
                        end else begin
                            cur_addr <= next_addr;
                            rd_byte  <= mem[next_addr];
                        end
                    end
                end
                WR_DATA: begin
                    shift_sr <= sr_next;
                    idx      <= idx + 5'd1;
                    if (idx == 5'd7) begin
                        idx <= 5'd0;
                        if (mode == MODE_BYTE) state <= IGNORE;
                        else                   cur_addr <= next_addr;
                    end
                end
                RD_MR: begin
                    so      <= rd_byte[7];
                    so_oe   <= 1'b1;
                    rd_byte <= {rd_byte[6:0], rd_byte[7]};
                end
                WR_MR: begin
                    shift_sr <= sr_next;
                    idx      <= idx + 5'd1;
                    if (idx == 5'd7) begin
                        if (sr_next[7:6] != 2'b11) mode <= sr_next[7:6];
                        state <= IGNORE;
                    end
                end
                IGNORE: state <= IGNORE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sram_model.sv
// Self-checking bench for spi_sram_model: directed vector table, corner-case
// sequences and randomized transactions against a byte-array reference model.
module tb_spi_sram_model;
    localparam int PAGE = 32;

    logic       sclk    = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce      = 1'b0;
    logic       si      = 1'b0;
    logic       so;
    logic       so_oe;
    logic [1:0] mode;

    spi_sram_model #(
        .INIT_FILE(""), .ADDR_BITS(24), .PAGE_BYTES(PAGE), .DUMMY_CYCLES(8)
    ) dut (
        .sclk(sclk), .reset_n(reset_n), .ce(ce), .si(si),
        .so(so), .so_oe(so_oe), .mode(mode)
    );

    always #5 sclk = ~sclk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mm [int];
    logic [1:0]  mmode;
    logic [7:0]  wdat [65];
    logic        oe_seen;
    logic [31:0] rd_data;
    logic [31:0] rd_oe;
    logic [7:0]  dm_oe;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are looked at after the next falling edge.
    task automatic clk_edge(input logic b, input logic c);
        si = b;
        ce = c;
        @(posedge sclk);
        @(negedge sclk);
        if (so_oe) oe_seen = 1'b1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) clk_edge(v[i], 1'b1);
    endtask

    task automatic start_txn(input logic [7:0] c);
        clk_edge(1'b0, 1'b1);
        send_bits(32'(c), 8);
    endtask

    task automatic end_txn();
        clk_edge(1'b0, 1'b0);
    endtask

    function automatic logic [23:0] adv(input logic [23:0] a);
        logic [23:0] off;
        if (mmode == 2'b10) begin
            off = (a % PAGE + 1) % PAGE;
            return a - (a % PAGE) + off;
        end
        return a + 24'd1;
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] addr, input int n);
        logic [31:0] r;
        logic [23:0] a;
        r = 32'd0;
        a = addr;
        for (int i = 0; i < n; i++) begin
            r = {r[23:0], mm[int'(a)]};
            a = adv(a);
        end
        return r;
    endfunction

    task automatic do_write(input logic [23:0] addr, input int n, input int extra);
        logic [23:0] a;
        a = addr;
        oe_seen = 1'b0;
        start_txn(8'h02);
        send_bits(32'(addr), 24);
        for (int i = 0; i < n; i++) send_bits(32'(wdat[i]), 8);
        if (extra > 0) send_bits(32'(wdat[n] >> (8 - extra)), extra);
        end_txn();
        for (int i = 0; i < n; i++) begin
            if (i > 0 && mmode == 2'b00) break;
            mm[int'(a)] = wdat[i];
            a = adv(a);
        end
    endtask

    task automatic read_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            clk_edge(1'($urandom_range(0, 1)), 1'b1);
            rd_data = {rd_data[30:0], so};
            rd_oe   = {rd_oe[30:0], so_oe};
        end
    endtask

    task automatic do_read(input logic [7:0] c, input logic [23:0] addr, input int nbits);
        rd_data = 32'd0;
        rd_oe   = 32'd0;
        dm_oe   = 8'd0;
        start_txn(c);
        send_bits(32'(addr), 24);
        if (c == 8'h0B) begin
            for (int i = 0; i < 8; i++) begin
                clk_edge(1'($urandom_range(0, 1)), 1'b1);
                dm_oe = {dm_oe[6:0], so_oe};
            end
        end
        read_bits(nbits);
        end_txn();
    endtask

    task automatic do_rdmr(input int nbits);
        rd_data = 32'd0;
        rd_oe   = 32'd0;
        start_txn(8'h05);
        read_bits(nbits);
        end_txn();
    endtask

    task automatic do_wrmr(input logic [7:0] v);
        start_txn(8'h01);
        send_bits(32'(v), 8);
        end_txn();
        if (v[7:6] != 2'b11) mmode = v[7:6];
    endtask

    function automatic logic [31:0] ones(input int nbits);
        return 32'hFFFF_FFFF >> (32 - nbits);
    endfunction

    initial begin
        int          op;
        int          n;
        int          nb;
        int          extra;
        logic [23:0] a;
        logic [7:0]  c;
        logic [31:0] exp;

        tbl[0] = '{8'h03, 24'h000010, 2, 32'h0000_A53C};
        tbl[1] = '{8'h0B, 24'h000000, 2, 32'h0000_5A77};
        tbl[2] = '{8'h03, 24'hFFFFFF, 2, 32'h0000_C35A};
        tbl[3] = '{8'h03, 24'h000001, 1, 32'h0000_0077};
        tbl[4] = '{8'h0B, 24'h000011, 1, 32'h0000_003C};
        tbl[5] = '{8'h03, 24'h000100, 2, 32'h0000_4455};
        tbl[6] = '{8'h0B, 24'hFFFFFF, 3, 32'h00C3_5A77};

        // Reset with ce high must still win.
        reset_n = 1'b0;
        ce = 1'b1;
        @(negedge sclk);
        clk_edge(1'b1, 1'b1);
        clk_edge(1'b1, 1'b1);
        check("rst_so", 32'(so), 32'd0);
        check("rst_so_oe", 32'(so_oe), 32'd0);
        check("rst_mode", 32'(mode), 32'h1);
        reset_n = 1'b1;
        end_txn();
        mmode = 2'b01;

        do_rdmr(16);
        check("rdmr_seq", rd_data, 32'h4040);
        check("rdmr_seq_oe", rd_oe, ones(16));

        // Preload FFFFE0..00003F through the SPI port in sequential mode.
        for (int i = 0; i < 64; i++) wdat[i] = 8'($urandom);
        do_write(24'hFFFFE0, 64, 0);
        for (int i = 0; i < 32; i++) wdat[i] = 8'($urandom);
        do_write(24'h000020, 32, 0);
        wdat[0] = 8'h5A; wdat[1] = 8'h77; do_write(24'h000000, 2, 0);
        wdat[0] = 8'hA5; wdat[1] = 8'h3C; do_write(24'h000010, 2, 0);
        wdat[0] = 8'hC3;                  do_write(24'hFFFFFF, 1, 0);
        wdat[0] = 8'hEE;                  do_write(24'h000020, 1, 0);
        wdat[0] = 8'h44; wdat[1] = 8'h55; do_write(24'h000100, 2, 0);
        wdat[0] = 8'h12;                  do_write(24'h000200, 1, 0);
        wdat[0] = 8'h00; wdat[1] = 8'h34; do_write(24'h000300, 2, 0);
        check("wr_seq_oe", 32'(oe_seen), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_read(tbl[i].cmd, tbl[i].addr, 8 * tbl[i].nbytes);
            check($sformatf("tbl%0d_data", i), rd_data, tbl[i].exp);
            check($sformatf("tbl%0d_oe", i), rd_oe, ones(8 * tbl[i].nbytes));
            if (tbl[i].cmd == 8'h0B) check($sformatf("tbl%0d_dummy_oe", i), 32'(dm_oe), 32'd0);
        end

        // Partial bytes are dropped; completed bytes before them stay.
        wdat[0] = 8'hFF;
        do_write(24'h000200, 0, 5);
        do_read(8'h03, 24'h000200, 8);
        check("partial_none", rd_data, 32'h12);
        wdat[0] = 8'hAB; wdat[1] = 8'hFF;
        do_write(24'h000300, 1, 3);
        do_read(8'h03, 24'h000300, 16);
        check("partial_after_full", rd_data, 32'hAB34);

        oe_seen = 1'b0;
        start_txn(8'h9F);
        for (int i = 0; i < 16; i++) clk_edge(1'($urandom_range(0, 1)), 1'b1);
        end_txn();
        check("bad_cmd_oe", 32'(oe_seen), 32'd0);
        check("bad_cmd_mode", 32'(mode), 32'h1);

        // Page mode: wrap inside the 32-byte page.
        do_wrmr(8'h80);
        check("wrmr_page", 32'(mode), 32'h2);
        do_rdmr(16);
        check("rdmr_page", rd_data, 32'h8080);
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
        do_write(24'h00001F, 3, 0);
        do_read(8'h03, 24'h00001F, 24);
        check("page_wrap_rd", rd_data, 32'h112233);
        do_read(8'h03, 24'h000000, 16);
        check("page_low_rd", rd_data, 32'h2233);
        do_read(8'h03, 24'h000020, 8);
        check("page_next_untouched", rd_data, 32'hEE);

        // Byte mode: one byte per transaction.
        do_wrmr(8'h00);
        check("wrmr_byte", 32'(mode), 32'h0);
        wdat[0] = 8'h99; wdat[1] = 8'h88;
        do_write(24'h000100, 2, 0);
        check("byte_wr_oe", 32'(oe_seen), 32'd0);
        do_read(8'h03, 24'h000100, 9);
        check("byte_rd", 32'(rd_data[8:1]), 32'h99);
        check("byte_rd_oe", 32'(rd_oe[8:0]), 32'h1FE);
        do_read(8'h03, 24'h000101, 8);
        check("byte_second_untouched", rd_data, 32'h55);
        do_wrmr(8'hC0);
        check("wrmr_11_keeps", 32'(mode), 32'h0);
        do_wrmr(8'h7F);
        check("wrmr_seq", 32'(mode), 32'h1);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            n  = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) a = 24'hFFFFE0 + 24'($urandom_range(0, 31));
            else                           a = 24'($urandom_range(0, 64 - n));
            if (op <= 1) begin
                do_wrmr(8'($urandom));
                check("rnd_mode", 32'(mode), 32'(mmode));
            end else if (op <= 4) begin
                for (int i = 0; i <= n; i++) wdat[i] = 8'($urandom);
                extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
                do_write(a, n, extra);
                check("rnd_wr_oe", 32'(oe_seen), 32'd0);
            end else if (op <= 8) begin
                c   = ($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03;
                nb  = (mmode == 2'b00) ? 1 : n;
                exp = model_read(a, nb);
                do_read(c, a, 8 * nb);
                check("rnd_rd_data", rd_data, exp);
                check("rnd_rd_oe", rd_oe, ones(8 * nb));
                if (c == 8'h0B) check("rnd_dummy_oe", 32'(dm_oe), 32'd0);
            end else begin
                do_rdmr(16);
                check("rnd_rdmr", rd_data, 32'({mmode, 6'b0, mmode, 6'b0}));
            end
        end

        // Reset in the middle of a READ, then restart straight away with ce held high.
        do_wrmr(8'h80);
        check("pre_rst_mode", 32'(mode), 32'h2);
        start_txn(8'h03);
        send_bits(32'h10, 24);
        for (int i = 0; i < 4; i++) clk_edge(1'b0, 1'b1);
        reset_n = 1'b0;
        clk_edge(1'b0, 1'b1);
        check("midrd_rst_so", 32'(so), 32'd0);
        check("midrd_rst_so_oe", 32'(so_oe), 32'd0);
        check("midrd_rst_mode", 32'(mode), 32'h1);
        mmode = 2'b01;
        reset_n = 1'b1;
        exp = model_read(24'h000010, 2);
        do_read(8'h03, 24'h000010, 16);
        check("post_rst_rd", rd_data, exp);
        check("post_rst_rd_oe", rd_oe, ones(16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
